// File: rtl/rtype_exec_sequencer_if.sv
// Issue, register-file and ALU signal bundle for rtype_exec_sequencer.
// slave = the sequencer, master = the surrounding core/environment.
`default_nettype none

interface rtype_exec_sequencer_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   logic            start;
   logic [31:0]     ir;
   logic            busy;
   logic            done;
   logic            illegal;
   logic            rf_re;
   logic [RA_W-1:0] rf_raddr;
   logic [XLEN-1:0] rf_rdata;
   logic            rf_we;
   logic [RA_W-1:0] rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [31:0]     alu_ir;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] retire_cnt;

   modport master (
      output start, ir, rf_rdata, alu_result,
      input  busy, done, illegal, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata,
             alu_ir, alu_a, alu_b, retire_cnt
   );

   modport slave (
      input  start, ir, rf_rdata, alu_result,
      output busy, done, illegal, rf_re, rf_raddr, rf_we, rf_waddr, rf_wdata,
             alu_ir, alu_a, alu_b, retire_cnt
   );
endinterface

`default_nettype wire

// File: rtl/rtype_exec_sequencer.sv
// Multi-cycle R-type sequencer: read rs1, read rs2, present to ALU, write rd.
// Optional macro RTYPE_X0_BYPASS_EN suppresses register-file reads of x0.
`default_nettype none

module rtype_exec_sequencer #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  wire logic              iCLK,
   input  wire logic              iRST,
   rtype_exec_sequencer_if.slave  bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD1  = 3'd1;
   localparam logic [2:0] S_RD2  = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

`ifdef RTYPE_X0_BYPASS_EN
   localparam bit X0_BYPASS = 1'b1;
`else
   localparam bit X0_BYPASS = 1'b0;
`endif

   logic [2:0]      state;
   logic [31:0]     ir_q;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] alu_b_q;
   logic [31:0]     alu_ir_q;
   logic [XLEN-1:0] retire_q;

   logic [RA_W-1:0] rs1;
   logic [RA_W-1:0] rs2;
   logic [RA_W-1:0] rd;
   logic            skip_rs1;
   logic            skip_rs2;
   logic            in_legal;

   assign rs1 = RA_W'(ir_q[19:15]);
   assign rs2 = RA_W'(ir_q[24:20]);
   assign rd  = RA_W'(ir_q[11:7]);

   assign skip_rs1 = X0_BYPASS && (rs1 == '0);
   assign skip_rs2 = X0_BYPASS && (rs2 == '0);

   // Only ADD..AND with func7=0, plus SUB and SRA, are accepted.
   assign in_legal = (bus.ir[6:0] == 7'h33) &&
                     ((bus.ir[31:25] == 7'h00) ||
                      ((bus.ir[31:25] == 7'h20) &&
                       ((bus.ir[14:12] == 3'd0) || (bus.ir[14:12] == 3'd5))));

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state    <= S_IDLE;
         ir_q     <= '0;
         op_a     <= '0;
         alu_b_q  <= '0;
         alu_ir_q <= '0;
         retire_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  ir_q  <= bus.ir;
                  state <= in_legal ? S_RD1 : S_ERR;
               end
            end
            S_RD1: state <= S_RD2;
            S_RD2: begin
               op_a     <= skip_rs1 ? '0 : bus.rf_rdata;
               alu_ir_q <= ir_q;
               state    <= S_EXEC;
            end
            S_EXEC: begin
               alu_b_q <= skip_rs2 ? '0 : bus.rf_rdata;
               state   <= S_WB;
            end
            S_WB: begin
               retire_q <= retire_q + XLEN'(1);
               state    <= S_IDLE;
            end
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from state so reset forces every strobe and bus to zero.
   always_comb begin
      bus.busy     = (state != S_IDLE);
      bus.done     = (state == S_WB) || (state == S_ERR);
      bus.illegal  = (state == S_ERR);
      bus.rf_re    = 1'b0;
      bus.rf_raddr = '0;
      bus.rf_we    = 1'b0;
      bus.rf_waddr = '0;
      bus.rf_wdata = '0;
      case (state)
         S_RD1: begin
            bus.rf_re    = !skip_rs1;
            bus.rf_raddr = rs1;
         end
         S_RD2: begin
            bus.rf_re    = !skip_rs2;
            bus.rf_raddr = rs2;
         end
         S_WB: begin
            bus.rf_we    = (rd != '0);
            bus.rf_waddr = rd;
            bus.rf_wdata = bus.alu_result;
         end
         default: ;
      endcase
   end

   assign bus.alu_a      = op_a;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_ir     = alu_ir_q;
   assign bus.retire_cnt = retire_q;

endmodule

`default_nettype wire

// File: tb/tb_rtype_exec_sequencer.sv
// Directed scoreboard bench for rtype_exec_sequencer with a register-file and ALU model.
`default_nettype none

module tb_rtype_exec_sequencer;

`ifdef RTYPE_X0_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rtype_exec_sequencer_if #(.XLEN(32), .RA_W(5)) bus ();

   rtype_exec_sequencer #(.XLEN(32), .RA_W(5)) dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   typedef struct {
      logic        illegal;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      int          done_cyc;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] rf [32];
   logic [31:0] exp_rf [32];
   logic [31:0] exp_retire;
   logic        pl_we;
   logic [4:0]  pl_addr;
   logic [31:0] pl_data;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [31:0] ref_alu(input logic [31:0] w, input logic [31:0] a,
                                           input logic [31:0] b);
      case (w[14:12])
         3'd0: ref_alu = w[30] ? a - b : a + b;
         3'd1: ref_alu = a << b[4:0];
         3'd2: ref_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: ref_alu = (a < b) ? 32'd1 : 32'd0;
         3'd4: ref_alu = a ^ b;
         3'd5: ref_alu = w[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: ref_alu = a | b;
         default: ref_alu = a & b;
      endcase
   endfunction

   always_comb bus.alu_result = ref_alu(bus.alu_ir, bus.alu_a, bus.alu_b);

   // Register file: one-cycle read latency, write on the DUT strobe, bench preload port.
   always @(posedge clk) begin
      if (bus.rf_re) bus.rf_rdata <= rf[bus.rf_raddr];
      if (pl_we) rf[pl_addr] <= pl_data;
      else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
      exp_rf[a] = d;
      pl_addr = a;
      pl_data = d;
      pl_we = 1'b1;
      tick();
      pl_we = 1'b0;
   endtask

   task automatic run_instr(input string tag, input logic [31:0] w);
      exp_t e;
      logic [4:0] rs1, rs2, rd;
      bit legal, got, exp_re;
      rs1 = w[19:15];
      rs2 = w[24:20];
      rd  = w[11:7];
      legal = (w[6:0] == 7'h33) && ((w[31:25] == 7'h00) ||
              ((w[31:25] == 7'h20) && ((w[14:12] == 3'd0) || (w[14:12] == 3'd5))));
      e.illegal  = !legal;
      e.a        = exp_rf[rs1];
      e.b        = exp_rf[rs2];
      e.wdata    = ref_alu(w, e.a, e.b);
      e.we       = legal && (rd != 5'd0);
      e.waddr    = rd;
      e.done_cyc = legal ? 4 : 1;
      sb.push_back(e);
      if (legal) exp_retire = exp_retire + 32'd1;
      if (e.we) exp_rf[rd] = e.wdata;
      bus.start = 1'b1;
      bus.ir = w;
      got = 1'b0;
      for (int c = 1; c <= 8 && !got; c++) begin
         tick();
         bus.start = 1'b0;
         bus.ir = $urandom;
         exp_re = legal && ((c == 1 && (rs1 != 5'd0 || !BYP)) ||
                            (c == 2 && (rs2 != 5'd0 || !BYP)));
         check({tag, "_re"}, 32'(bus.rf_re), 32'(exp_re));
         if (exp_re) check({tag, "_raddr"}, 32'(bus.rf_raddr), (c == 1) ? 32'(rs1) : 32'(rs2));
         if (bus.done) begin
            got = 1'b1;
            e = sb.pop_front();
            check({tag, "_done_cyc"}, 32'(c), 32'(e.done_cyc));
            check({tag, "_illegal"}, 32'(bus.illegal), 32'(e.illegal));
            check({tag, "_we"}, 32'(bus.rf_we), 32'(e.we));
            if (e.we) begin
               check({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(e.waddr));
               check({tag, "_wdata"}, bus.rf_wdata, e.wdata);
            end
            if (!e.illegal) begin
               check({tag, "_alu_a"}, bus.alu_a, (BYP && rs1 == 5'd0) ? 32'd0 : e.a);
               check({tag, "_alu_b"}, bus.alu_b, (BYP && rs2 == 5'd0) ? 32'd0 : e.b);
            end
         end else begin
            check({tag, "_we_early"}, 32'(bus.rf_we), 32'd0);
         end
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      tick();
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      check({tag, "_retire"}, bus.retire_cnt, exp_retire);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
      check({tag, "_re"}, 32'(bus.rf_re), 32'd0);
      check({tag, "_we"}, 32'(bus.rf_we), 32'd0);
      check({tag, "_raddr"}, 32'(bus.rf_raddr), 32'd0);
      check({tag, "_waddr"}, 32'(bus.rf_waddr), 32'd0);
      check({tag, "_wdata"}, bus.rf_wdata, 32'd0);
      check({tag, "_alu_a"}, bus.alu_a, 32'd0);
      check({tag, "_alu_b"}, bus.alu_b, 32'd0);
      check({tag, "_alu_ir"}, bus.alu_ir, 32'd0);
      check({tag, "_retire"}, bus.retire_cnt, 32'd0);
   endtask

   initial begin
      int dones, first_done, second_done;
      bit got;
      bus.start = 1'b0;
      bus.ir = '0;
      pl_we = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      exp_retire = '0;
      for (int i = 0; i < 32; i++) exp_rf[i] = '0;
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         pl_addr = 5'(i);
         pl_we = 1'b1;
         tick();
      end
      pl_we = 1'b0;
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      set_reg(5'd1, 32'd5);
      set_reg(5'd2, 32'd7);
      run_instr("add", 32'h002081B3);

      set_reg(5'd1, 32'hFFFF_FFFF);
      set_reg(5'd2, 32'd1);
      run_instr("sub", 32'h40208233);
      check("sub_value", exp_rf[4], 32'hFFFF_FFFE);
      run_instr("slt", 32'h0020A2B3);
      check("slt_value", exp_rf[5], 32'd1);
      run_instr("add_rd0", 32'h00208033);
      run_instr("ill_addi", 32'h00000013);
      run_instr("ill_f7_f3", 32'h4020C233);
      run_instr("add_x0", 32'h002001B3);

      // Held start: accepts only from IDLE, so completions land on cycles 4 and 9.
      set_reg(5'd1, 32'd5);
      set_reg(5'd2, 32'd7);
      bus.start = 1'b1;
      bus.ir = 32'h002081B3;
      dones = 0;
      first_done = -1;
      second_done = -1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (bus.done) begin
            dones++;
            if (dones == 1) first_done = c;
            if (dones == 2) second_done = c;
            check("held_wdata", bus.rf_wdata, 32'd12);
         end
      end
      bus.start = 1'b0;
      check("held_count", 32'(dones), 32'd2);
      check("held_first", 32'(first_done), 32'd4);
      check("held_second", 32'(second_done), 32'd9);
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
         tick();
         if (bus.done) got = 1'b1;
      end
      check("held_drain", 32'(got), 32'd1);
      tick();
      exp_retire = exp_retire + 32'd3;
      check("held_retire", bus.retire_cnt, exp_retire);

      // Reset while in EXEC: everything clears, no write-back follows.
      bus.start = 1'b1;
      bus.ir = 32'h002081B3;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("rst_exec");
      for (int c = 0; c < 5; c++) begin
         tick();
         check("post_rst_done", 32'(bus.done), 32'd0);
         check("post_rst_we", 32'(bus.rf_we), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
